// File: rtl/writeback_arbiter.sv
// Merges single-cycle results (A) and queued multicycle results (B) onto the
// single register-file write port, and tracks destinations with writes still pending.
module writeback_arbiter #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 5,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                           Clk,
    input  logic                           Rst,
    input  logic                           a_valid,
    output logic                           a_ready,
    input  logic [ADDR_WIDTH-1:0]          a_addr,
    input  logic [DATA_WIDTH-1:0]          a_data,
    input  logic                           b_valid,
    output logic                           b_ready,
    input  logic [ADDR_WIDTH-1:0]          b_addr,
    input  logic [DATA_WIDTH-1:0]          b_data,
    output logic [ADDR_WIDTH-1:0]          writeAddr,
    output logic [DATA_WIDTH-1:0]          data_in,
    output logic                           write_En,
    output logic [$clog2(FIFO_DEPTH):0]    fifo_count,
    output logic [(1<<ADDR_WIDTH)-1:0]     pending_mask
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
    localparam logic GRANT_A = 1'b0;
    localparam logic GRANT_B = 1'b1;

    logic [ADDR_WIDTH-1:0] fifo_addr_q [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0] fifo_addr_d [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] fifo_data_q [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] fifo_data_d [FIFO_DEPTH];
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]         fifo_count_q, fifo_count_d;
    logic                  last_grant_q, last_grant_d;
    logic [ADDR_WIDTH-1:0] write_addr_q, write_addr_d;
    logic [DATA_WIDTH-1:0] write_data_q, write_data_d;
    logic                  write_en_q, write_en_d;

    logic                  push, grant_a, grant_b;
    logic [PW-1:0]         slot;

    always_comb begin
        b_ready      = (fifo_count_q != DEPTH_C);
        // Ready terms look only at queue state and history, never at the requesting valid.
        a_ready      = (fifo_count_q == '0) || (last_grant_q == GRANT_B);
        push         = b_valid && b_ready;
        grant_a      = a_valid && a_ready;
        grant_b      = (fifo_count_q != '0) && !grant_a;

        fifo_addr_d  = fifo_addr_q;
        fifo_data_d  = fifo_data_q;
        rd_ptr_d     = rd_ptr_q;
        wr_ptr_d     = wr_ptr_q;
        last_grant_d = last_grant_q;
        write_addr_d = write_addr_q;
        write_data_d = write_data_q;
        write_en_d   = 1'b0;

        if (push) begin
            fifo_addr_d[wr_ptr_q] = b_addr;
            fifo_data_d[wr_ptr_q] = b_data;
            wr_ptr_d              = wr_ptr_q + PW'(1);
        end
        fifo_count_d = fifo_count_q + CW'(push) - CW'(grant_b);

        if (grant_a) begin
            write_addr_d = a_addr;
            write_data_d = a_data;
            write_en_d   = (a_addr != '0);
            last_grant_d = GRANT_A;
        end else if (grant_b) begin
            write_addr_d = fifo_addr_q[rd_ptr_q];
            write_data_d = fifo_data_q[rd_ptr_q];
            write_en_d   = (fifo_addr_q[rd_ptr_q] != '0);
            rd_ptr_d     = rd_ptr_q + PW'(1);
            last_grant_d = GRANT_B;
        end
    end

    // Occupied slots are the fifo_count entries starting at the read pointer.
    always_comb begin
        pending_mask = '0;
        slot         = '0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            slot = rd_ptr_q + PW'(i);
            if (CW'(i) < fifo_count_q) begin
                pending_mask[fifo_addr_q[slot]] = 1'b1;
            end
        end
        if (write_en_q) begin
            pending_mask[write_addr_q] = 1'b1;
        end
        pending_mask[0] = 1'b0;
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_addr_q[i] <= '0;
                fifo_data_q[i] <= '0;
            end
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            fifo_count_q <= '0;
            last_grant_q <= GRANT_B;
            write_addr_q <= '0;
            write_data_q <= '0;
            write_en_q   <= 1'b0;
        end else begin
            fifo_addr_q  <= fifo_addr_d;
            fifo_data_q  <= fifo_data_d;
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            fifo_count_q <= fifo_count_d;
            last_grant_q <= last_grant_d;
            write_addr_q <= write_addr_d;
            write_data_q <= write_data_d;
            write_en_q   <= write_en_d;
        end
    end

    assign writeAddr  = write_addr_q;
    assign data_in    = write_data_q;
    assign write_En   = write_en_q;
    assign fifo_count = fifo_count_q;

endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed bench for writeback_arbiter: stimulus queues the hand-derived commit
// sequence, a negedge monitor pops and compares every register-file write.
module tb_writeback_arbiter;

    logic        Clk = 1'b0;
    logic        Rst;
    logic        a_valid, b_valid;
    logic        a_ready, b_ready;
    logic [4:0]  a_addr, b_addr, writeAddr;
    logic [63:0] a_data, b_data, data_in;
    logic        write_En;
    logic [2:0]  fifo_count;
    logic [31:0] pending_mask;

    writeback_arbiter #(.DATA_WIDTH(64), .ADDR_WIDTH(5), .FIFO_DEPTH(4)) dut (
        .Clk(Clk), .Rst(Rst),
        .a_valid(a_valid), .a_ready(a_ready), .a_addr(a_addr), .a_data(a_data),
        .b_valid(b_valid), .b_ready(b_ready), .b_addr(b_addr), .b_data(b_data),
        .writeAddr(writeAddr), .data_in(data_in), .write_En(write_En),
        .fifo_count(fifo_count), .pending_mask(pending_mask)
    );

    always #5 Clk = ~Clk;

    typedef struct packed {
        logic [4:0]  addr;
        logic [63:0] data;
    } wb_t;

    wb_t exp_q[$];
    wb_t mon_e;
    int  checks   = 0;
    int  failures = 0;

    localparam logic [63:0] ABASE = 64'hA5A5_0000_0000_0000;
    localparam logic [63:0] BBASE = 64'h7B7B_0000_0000_0000;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic expect_wb(input logic [4:0] addr, input logic [63:0] data);
        wb_t e;
        e.addr = addr;
        e.data = data;
        exp_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while ((fifo_count != 0 || write_En) && n < 30) begin
            tick();
            n++;
        end
        check(name, (fifo_count == 0 && !write_En), 1);
    endtask

    // Both sources held valid; A data advances only on cycles where A is expected to win.
    task automatic run_contention(input int n, input logic [63:0] abase, input logic [63:0] bbase);
        int a_idx [6] = '{0, 1, 1, 2, 2, 3};
        int a_rdy [6] = '{1, 0, 1, 0, 1, 0};
        for (int i = 0; i < n; i++) begin
            a_valid = 1'b1; a_addr = 5'd9; a_data = abase + 64'(a_idx[i]);
            b_valid = 1'b1; b_addr = 5'd7; b_data = bbase + 64'(i);
            check($sformatf("contend_a_ready_%0d", i), a_ready, a_rdy[i]);
            tick();
            if (i == 0) check("contend_pending", pending_mask, (32'd1 << 7) | (32'd1 << 9));
        end
        a_valid = 1'b0;
        b_valid = 1'b0;
    endtask

    always @(negedge Clk) begin
        if (write_En === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_commit actual addr=%0d data=%0h expected none", writeAddr, data_in);
            end else begin
                mon_e = exp_q.pop_front();
                check("commit_addr", writeAddr, mon_e.addr);
                check("commit_data", data_in, mon_e.data);
            end
        end
        if (Rst === 1'b0) check("pending_bit0", pending_mask[0], 0);
    end

    initial begin
        int  npush;
        logic full_seen;
        Rst = 1'b1;
        a_valid = 0; a_addr = 0; a_data = 0;
        b_valid = 0; b_addr = 0; b_data = 0;
        tick(); tick();
        Rst = 1'b0;
        check("rst_write_En", write_En, 0);
        check("rst_writeAddr", writeAddr, 0);
        check("rst_data_in", data_in, 0);
        check("rst_fifo_count", fifo_count, 0);
        check("rst_pending", pending_mask, 0);
        check("rst_b_ready", b_ready, 1);
        check("rst_a_ready", a_ready, 1);

        // A only
        expect_wb(5'd5, 64'h1234);
        a_valid = 1; a_addr = 5'd5; a_data = 64'h1234;
        check("a_only_ready", a_ready, 1);
        tick();
        a_valid = 0;
        check("a_only_we", write_En, 1);
        check("a_only_pending", pending_mask, 32'd1 << 5);
        tick();
        check("a_only_we_drop", write_En, 0);
        check("a_only_hold_addr", writeAddr, 5);
        check("a_only_pending_clr", pending_mask, 0);

        // B fill with A contending on x0 so the queue only drains every other cycle
        npush = 0;
        full_seen = 0;
        for (int i = 1; i <= 12; i++) begin
            if (!b_ready) begin
                full_seen = 1;
                break;
            end
            a_valid = 1; a_addr = 5'd0; a_data = 64'hDEAD;
            b_valid = 1; b_addr = 5'(i); b_data = BBASE + 64'(i);
            expect_wb(5'(i), BBASE + 64'(i));
            npush++;
            tick();
        end
        a_valid = 0;
        b_valid = 0;
        check("fill_reached_full", full_seen, 1);
        check("fill_pushes", npush, 7);
        check("fill_count", fifo_count, 4);
        check("fill_b_ready", b_ready, 0);
        check("fill_a_ready", a_ready, 0);
        check("fill_pending", pending_mask, 32'h0000_00F0);
        tick();
        check("fill_pop_count", fifo_count, 3);
        check("fill_pop_b_ready", b_ready, 1);
        drain("fill_drain");
        check("fill_drain_pending", pending_mask, 0);

        // Contention from reset: A, B alternate
        Rst = 1; tick(); Rst = 0;
        expect_wb(9, ABASE + 0); expect_wb(7, BBASE + 0);
        expect_wb(9, ABASE + 1); expect_wb(7, BBASE + 1);
        expect_wb(9, ABASE + 2); expect_wb(7, BBASE + 2);
        expect_wb(7, BBASE + 3); expect_wb(7, BBASE + 4); expect_wb(7, BBASE + 5);
        run_contention(6, ABASE, BBASE);
        check("contend_count", fifo_count, 3);
        drain("contend_drain");

        // x0 on both sources
        a_valid = 1; a_addr = 5'd0; a_data = 64'hFFFF;
        check("x0_a_ready", a_ready, 1);
        tick();
        a_valid = 0;
        check("x0_a_we", write_En, 0);
        check("x0_a_pending", pending_mask, 0);
        b_valid = 1; b_addr = 5'd0; b_data = 64'hFFFF;
        tick();
        b_valid = 0;
        check("x0_b_count", fifo_count, 1);
        check("x0_b_pending", pending_mask, 0);
        tick();
        check("x0_b_we", write_En, 0);
        check("x0_b_count_after", fifo_count, 0);

        // Duplicate destination 12
        expect_wb(12, 64'hC1); expect_wb(12, 64'hC2);
        b_valid = 1; b_addr = 5'd12; b_data = 64'hC1;
        tick();
        check("dup_pending_0", pending_mask, 32'd1 << 12);
        b_data = 64'hC2;
        tick();
        b_valid = 0;
        check("dup_pending_1", pending_mask, 32'd1 << 12);
        tick();
        check("dup_we_2", write_En, 1);
        check("dup_pending_2", pending_mask, 32'd1 << 12);
        tick();
        check("dup_we_3", write_En, 0);
        check("dup_pending_3", pending_mask, 0);

        // Reset with three entries queued and a commit in the output register
        expect_wb(9, ABASE + 64'h100); expect_wb(7, BBASE + 64'h100);
        expect_wb(9, ABASE + 64'h101); expect_wb(7, BBASE + 64'h101);
        expect_wb(9, ABASE + 64'h102);
        run_contention(5, ABASE + 64'h100, BBASE + 64'h100);
        check("pre_rst_count", fifo_count, 3);
        check("pre_rst_pending", pending_mask, (32'd1 << 7) | (32'd1 << 9));
        Rst = 1;
        tick();
        Rst = 0;
        check("mid_rst_count", fifo_count, 0);
        check("mid_rst_pending", pending_mask, 0);
        check("mid_rst_we", write_En, 0);
        check("mid_rst_b_ready", b_ready, 1);
        tick(); tick();
        check("post_rst_we", write_En, 0);
        check("scoreboard_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
